axist_h2h_test_sequencer: RTL and testbench

//  Mgmt-side controller that runs one AXI-ST H2H loopback test through the CSR Avalon-MM slave port.
//  On start: waits for tx/rx online, programs delay X/Y/Z and patgen config, enables patgen, then polls

---
 rtl/axist_h2h_seq_pkg.sv | 56 +++++
 rtl/axist_avmm_master_if.sv | 111 +++++++++++
 rtl/axist_h2h_test_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_axist_h2h_test_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axist_h2h_seq_pkg.sv
// Shared definitions for the AXI-ST H2H loopback test sequencer.
//   - sequencer and Avalon-MM engine state enums
//   - error codes reported on o_err
//   - CSR addresses and bit positions of the loopback block
//   - helper that packs the pattern-generator configuration word
package axist_h2h_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_ONL,
    S_WR_DX,
    S_WR_DY,
    S_WR_DZ,
    S_WR_CFG,
    S_WR_EN,
    S_POLL_GAP,
    S_RD_STAT,
    S_CHECK,
    S_DONE,
    S_FAIL
  } seq_state_e;

  typedef enum logic [1:0] {
    E_IDLE,
    E_WR,
    E_RD,
    E_RDV
  } eng_state_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_ONLINE_TMO = 3'd1,
    ERR_AVMM_TMO   = 3'd2,
    ERR_POLL_TMO   = 3'd3,
    ERR_CHK_FAIL   = 3'd4
  } err_e;

  localparam logic [31:0] ADDR_DLY_X      = 32'h0000_0010;
  localparam logic [31:0] ADDR_DLY_Y      = 32'h0000_0014;
  localparam logic [31:0] ADDR_DLY_Z      = 32'h0000_0018;
  localparam logic [31:0] ADDR_PATGEN_CFG = 32'h0000_001C;
  localparam logic [31:0] ADDR_STATUS     = 32'h0000_0020;

  localparam int PATGEN_EN_BIT = 31;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_PASS_BIT = 0;

  localparam logic [31:0] PATGEN_EN_MASK = 32'(1) << PATGEN_EN_BIT;

  function automatic logic [31:0] patgen_cfg(input logic [1:0] sel,
                                             input logic [8:0] cnt,
                                             input logic       cntus);
    return {20'b0, cntus, cnt, sel};
  endfunction

endpackage

// File: rtl/axist_avmm_master_if.sv
// Single-access Avalon-MM master engine.
//   req/we/addr/wdata : one-cycle request pulse from the sequencer (accepted in idle only)
//   ack               : one-cycle pulse when the access completed (rdata valid for reads)
//   tmo               : one-cycle pulse when waitrequest or readdatavalid waited too long
//   avmm_*            : Avalon-MM master signals, all registered
// A write stays asserted with stable address/data while waitrequest is high.
// A read is asserted until accepted, then the engine waits for readdatavalid.
module axist_avmm_master_if
  import axist_h2h_seq_pkg::*;
#(
  parameter int AVMM_TMO = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        tmo,
  output logic [31:0] avmm_address,
  output logic        avmm_write,
  output logic        avmm_read,
  output logic [31:0] avmm_writedata,
  input  logic [31:0] avmm_readdata,
  input  logic        avmm_rdvalid,
  input  logic        avmm_waitreq
);

  // Counter only needs to reach AVMM_TMO-1: the cycle that would make it
  // AVMM_TMO is the one where the request is dropped.
  localparam int CW = (AVMM_TMO < 2) ? 1 : $clog2(AVMM_TMO);
  localparam logic [CW-1:0] CNT_LAST = CW'(AVMM_TMO - 1);

  eng_state_e    st;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= E_IDLE;
      cnt            <= '0;
      ack            <= 1'b0;
      tmo            <= 1'b0;
      rdata          <= '0;
      avmm_address   <= '0;
      avmm_write     <= 1'b0;
      avmm_read      <= 1'b0;
      avmm_writedata <= '0;
    end else begin
      ack <= 1'b0;
      tmo <= 1'b0;
      case (st)
        E_IDLE: begin
          if (req) begin
            avmm_address <= addr;
            cnt          <= '0;
            if (we) begin
              avmm_write     <= 1'b1;
              avmm_writedata <= wdata;
              st             <= E_WR;
            end else begin
              avmm_read <= 1'b1;
              st        <= E_RD;
            end
          end
        end
        E_WR: begin
          if (!avmm_waitreq) begin
            avmm_write <= 1'b0;
            ack        <= 1'b1;
            st         <= E_IDLE;
          end else if (cnt == CNT_LAST) begin
            avmm_write <= 1'b0;
            tmo        <= 1'b1;
            st         <= E_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        E_RD: begin
          if (!avmm_waitreq) begin
            avmm_read <= 1'b0;
            cnt       <= '0;
            st        <= E_RDV;
          end else if (cnt == CNT_LAST) begin
            avmm_read <= 1'b0;
            tmo       <= 1'b1;
            st        <= E_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        E_RDV: begin
          if (avmm_rdvalid) begin
            rdata <= avmm_readdata;
            ack   <= 1'b1;
            st    <= E_IDLE;
          end else if (cnt == CNT_LAST) begin
            tmo <= 1'b1;
            st  <= E_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= E_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axist_h2h_test_sequencer.sv
// Management-side controller running one AXI-ST H2H loopback test over the
// CSR Avalon-MM port: wait for link online, program delays X/Y/Z and the
// pattern generator, enable it, then poll the checker status.
//   i_start                      : start pulse (honoured in IDLE/DONE/FAIL only)
//   i_delay_*, i_patgen_*,
//   i_cntus_en                   : test configuration, sampled on start
//   i_tx_online, i_rx_online     : link status
//   o_avmm_* / i_avmm_*          : Avalon-MM master towards the CSR slave
//   o_busy                       : test in progress
//   o_done, o_pass, o_err        : sticky result, cleared by the next start
module axist_h2h_test_sequencer
  import axist_h2h_seq_pkg::*;
#(
  parameter int ONLINE_TMO = 65535,
  parameter int POLL_GAP   = 64,
  parameter int POLL_MAX   = 1024,
  parameter int AVMM_TMO   = 255
) (
  input  logic        mgmt_clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_delay_x,
  input  logic [31:0] i_delay_y,
  input  logic [31:0] i_delay_z,
  input  logic [1:0]  i_patgen_sel,
  input  logic [8:0]  i_patgen_cnt,
  input  logic        i_cntus_en,
  input  logic        i_tx_online,
  input  logic        i_rx_online,
  output logic [31:0] o_avmm_address,
  output logic        o_avmm_write,
  output logic        o_avmm_read,
  output logic [31:0] o_avmm_writedata,
  input  logic [31:0] i_avmm_readdata,
  input  logic        i_avmm_rdvalid,
  input  logic        i_avmm_waitreq,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [2:0]  o_err
);

  localparam logic [31:0] ONL_LAST  = 32'(ONLINE_TMO - 1);
  localparam logic [31:0] GAP_LAST  = 32'(POLL_GAP - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_MAX - 1);

  seq_state_e  state;
  logic [31:0] cnt;
  logic [31:0] poll_cnt;
  logic [31:0] dly_x, dly_y, dly_z, cfg;
  logic        stat_pass;
  err_e        err;

  logic        req, we;
  logic [31:0] addr, wdata;
  logic        eng_ack, eng_tmo;
  logic [31:0] eng_rdata;
  logic        unused_rdata;

  assign unused_rdata = ^{eng_rdata[31:2]};
  assign o_err        = err;

  axist_avmm_master_if #(.AVMM_TMO(AVMM_TMO)) u_avmm (
    .clk            (mgmt_clk),
    .rst_n          (rst_n),
    .req            (req),
    .we             (we),
    .addr           (addr),
    .wdata          (wdata),
    .ack            (eng_ack),
    .rdata          (eng_rdata),
    .tmo            (eng_tmo),
    .avmm_address   (o_avmm_address),
    .avmm_write     (o_avmm_write),
    .avmm_read      (o_avmm_read),
    .avmm_writedata (o_avmm_writedata),
    .avmm_readdata  (i_avmm_readdata),
    .avmm_rdvalid   (i_avmm_rdvalid),
    .avmm_waitreq   (i_avmm_waitreq)
  );

  // Each access is launched by a one-cycle req pulse issued on the transition
  // into the access state, so the engine never sees a stale request after ack.
  always_ff @(posedge mgmt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      poll_cnt  <= '0;
      dly_x     <= '0;
      dly_y     <= '0;
      dly_z     <= '0;
      cfg       <= '0;
      stat_pass <= 1'b0;
      req       <= 1'b0;
      we        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_pass    <= 1'b0;
      err       <= ERR_NONE;
    end else begin
      req <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (i_start) begin
            dly_x    <= i_delay_x;
            dly_y    <= i_delay_y;
            dly_z    <= i_delay_z;
            cfg      <= patgen_cfg(i_patgen_sel, i_patgen_cnt, i_cntus_en);
            cnt      <= '0;
            poll_cnt <= '0;
            o_busy   <= 1'b1;
            o_done   <= 1'b0;
            o_pass   <= 1'b0;
            err      <= ERR_NONE;
            state    <= S_WAIT_ONL;
          end
        end
        S_WAIT_ONL: begin
          if (i_tx_online && i_rx_online) begin
            req <= 1'b1; we <= 1'b1; addr <= ADDR_DLY_X; wdata <= dly_x;
            state <= S_WR_DX;
          end else if (cnt == ONL_LAST) begin
            o_busy <= 1'b0; o_done <= 1'b1; err <= ERR_ONLINE_TMO;
            state  <= S_FAIL;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_WR_DX, S_WR_DY, S_WR_DZ, S_WR_CFG, S_WR_EN, S_RD_STAT: begin
          if (eng_tmo) begin
            o_busy <= 1'b0; o_done <= 1'b1; err <= ERR_AVMM_TMO;
            state  <= S_FAIL;
          end else if (eng_ack) begin
            case (state)
              S_WR_DX: begin
                req <= 1'b1; we <= 1'b1; addr <= ADDR_DLY_Y; wdata <= dly_y;
                state <= S_WR_DY;
              end
              S_WR_DY: begin
                req <= 1'b1; we <= 1'b1; addr <= ADDR_DLY_Z; wdata <= dly_z;
                state <= S_WR_DZ;
              end
              S_WR_DZ: begin
                req <= 1'b1; we <= 1'b1; addr <= ADDR_PATGEN_CFG; wdata <= cfg;
                state <= S_WR_CFG;
              end
              S_WR_CFG: begin
                req <= 1'b1; we <= 1'b1; addr <= ADDR_PATGEN_CFG;
                wdata <= cfg | PATGEN_EN_MASK;
                state <= S_WR_EN;
              end
              S_WR_EN: begin
                cnt   <= '0;
                state <= S_POLL_GAP;
              end
              default: begin
                // status read returned
                poll_cnt <= poll_cnt + 32'd1;
                if (eng_rdata[STAT_DONE_BIT]) begin
                  stat_pass <= eng_rdata[STAT_PASS_BIT];
                  state     <= S_CHECK;
                end else if (poll_cnt == POLL_LAST) begin
                  o_busy <= 1'b0; o_done <= 1'b1; err <= ERR_POLL_TMO;
                  state  <= S_FAIL;
                end else begin
                  cnt   <= '0;
                  state <= S_POLL_GAP;
                end
              end
            endcase
          end
        end
        S_POLL_GAP: begin
          if (cnt == GAP_LAST) begin
            req <= 1'b1; we <= 1'b0; addr <= ADDR_STATUS;
            state <= S_RD_STAT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_CHECK: begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
          if (stat_pass) begin
            o_pass <= 1'b1;
            state  <= S_DONE;
          end else begin
            err   <= ERR_CHK_FAIL;
            state <= S_FAIL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axist_h2h_test_sequencer.sv
// Self-checking bench for axist_h2h_test_sequencer: a behavioural CSR slave
// records accepted writes and serves status reads from a table; expected
// writes and outcome are derived from the test configuration.
module tb_axist_h2h_test_sequencer;

  localparam int ONLINE_TMO = 100;
  localparam int POLL_GAP   = 8;
  localparam int POLL_MAX   = 4;
  localparam int AVMM_TMO   = 16;

  localparam logic [31:0] A_DX   = 32'h10;
  localparam logic [31:0] A_DY   = 32'h14;
  localparam logic [31:0] A_DZ   = 32'h18;
  localparam logic [31:0] A_CFG  = 32'h1C;
  localparam logic [31:0] A_STAT = 32'h20;

  logic        mgmt_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dx = '0, dy = '0, dz = '0;
  logic [1:0]  sel = '0;
  logic [8:0]  pcnt = '0;
  logic        cntus = 1'b0;
  logic        tx_on = 1'b0, rx_on = 1'b0;
  logic [31:0] av_addr, av_wdata;
  logic [31:0] av_rdata = '0;
  logic        av_wr, av_rd;
  logic        av_rdv = 1'b0, av_wait = 1'b0;
  logic        busy, done, pass;
  logic [2:0]  err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // slave model state
  bit          stuck = 0;
  logic [31:0] stall_addr = '1;
  int          stall_cfg = 0;
  int          stall_left = 0;
  bit          acc_active = 0;
  logic [31:0] acc_addr, acc_data;
  bit          stable_ok = 1;
  int          rd_wait = 0;
  int          rd_idx = 0;
  logic [31:0] stat_tab[8];
  logic [63:0] wr_q[$];
  int          n_reads = 0;
  int          rw_both = 0;
  int          last_done_cyc = 0;
  int          min_gap = 1000000;
  int          wr_high = 0;
  int          wr_high_max = 0;

  // expected configuration
  logic [31:0] e_dx, e_dy, e_dz, e_cfg;

  axist_h2h_test_sequencer #(
    .ONLINE_TMO(ONLINE_TMO), .POLL_GAP(POLL_GAP),
    .POLL_MAX(POLL_MAX), .AVMM_TMO(AVMM_TMO)
  ) dut (
    .mgmt_clk(mgmt_clk), .rst_n(rst_n), .i_start(start),
    .i_delay_x(dx), .i_delay_y(dy), .i_delay_z(dz),
    .i_patgen_sel(sel), .i_patgen_cnt(pcnt), .i_cntus_en(cntus),
    .i_tx_online(tx_on), .i_rx_online(rx_on),
    .o_avmm_address(av_addr), .o_avmm_write(av_wr), .o_avmm_read(av_rd),
    .o_avmm_writedata(av_wdata), .i_avmm_readdata(av_rdata),
    .i_avmm_rdvalid(av_rdv), .i_avmm_waitreq(av_wait),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err(err)
  );

  always #5 mgmt_clk = ~mgmt_clk;
  always @(posedge mgmt_clk) cyc <= cyc + 1;

  // CSR slave: waitrequest/readdatavalid are updated on the falling edge
  always @(negedge mgmt_clk) begin
    if (!rst_n) begin
      av_wait = 0; av_rdv = 0; acc_active = 0; rd_wait = 0;
    end else begin
      av_rdv = 0;
      if (rd_wait > 0) begin
        rd_wait--;
        if (rd_wait == 0) begin
          av_rdv = 1;
          av_rdata = (rd_idx < 8) ? stat_tab[rd_idx] : 32'h0;
          rd_idx++;
          last_done_cyc = cyc;
        end
      end
      if (av_wr && av_rd) rw_both++;
      if (!(av_wr || av_rd)) begin
        acc_active = 0;
        av_wait = 0;
      end else begin
        if (!acc_active) begin
          acc_active = 1;
          acc_addr = av_addr;
          acc_data = av_wdata;
          wr_high = 0;
          stall_left = stuck ? (1 << 30) : ((av_addr == stall_addr) ? stall_cfg : 0);
          if (av_rd) begin
            n_reads++;
            if (cyc - last_done_cyc < min_gap) min_gap = cyc - last_done_cyc;
          end
        end else if (av_addr !== acc_addr || (av_wr && av_wdata !== acc_data)) begin
          stable_ok = 0;
        end
        if (av_wr) begin
          wr_high++;
          if (wr_high > wr_high_max) wr_high_max = wr_high;
        end
        if (stall_left > 0) begin
          av_wait = 1;
          stall_left--;
        end else begin
          av_wait = 0;
          acc_active = 0;
          if (av_wr) begin
            wr_q.push_back({av_addr, av_wdata});
            last_done_cyc = cyc;
          end else begin
            rd_wait = 2;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    wr_q.delete();
    n_reads = 0; rd_idx = 0; rw_both = 0; min_gap = 1000000;
    wr_high_max = 0; stable_ok = 1;
  endtask

  task automatic new_cfg();
    dx = $urandom; dy = $urandom; dz = $urandom;
    sel = 2'($urandom_range(0, 3));
    pcnt = 9'($urandom_range(0, 511));
    cntus = 1'($urandom_range(0, 1));
    e_dx = dx; e_dy = dy; e_dz = dz;
    e_cfg = {20'b0, cntus, pcnt, sel};
  endtask

  task automatic do_start();
    @(posedge mgmt_clk); #1 start = 1;
    @(posedge mgmt_clk); #1 start = 0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge mgmt_clk); #1 n++;
    end
  endtask

  // Outcome of the run from the status table: first done reply within POLL_MAX reads decides
  task automatic model_outcome(output int nrd, output logic p, output logic [2:0] e);
    nrd = POLL_MAX; p = 0; e = 3'd3;
    for (int i = 0; i < POLL_MAX; i++) begin
      if (stat_tab[i][1]) begin
        nrd = i + 1;
        p = stat_tab[i][0];
        e = p ? 3'd0 : 3'd4;
        break;
      end
    end
  endtask

  task automatic check_writes(input string tag);
    logic [63:0] exp_w[5];
    exp_w[0] = {A_DX, e_dx};
    exp_w[1] = {A_DY, e_dy};
    exp_w[2] = {A_DZ, e_dz};
    exp_w[3] = {A_CFG, e_cfg};
    exp_w[4] = {A_CFG, e_cfg | 32'h8000_0000};
    chk({tag, "_nwr"}, wr_q.size(), 5);
    if (wr_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("%s_wr%0d_addr", tag, i), wr_q[i][63:32], exp_w[i][63:32]);
        chk($sformatf("%s_wr%0d_data", tag, i), wr_q[i][31:0], exp_w[i][31:0]);
      end
    end
  endtask

  task automatic check_result(input string tag);
    int nrd; logic p; logic [2:0] e;
    model_outcome(nrd, p, e);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_pass"}, pass, p);
    chk({tag, "_err"}, err, e);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_nreads"}, n_reads, nrd);
    chk({tag, "_gap_ok"}, (min_gap >= POLL_GAP), 1);
    chk({tag, "_no_rw_overlap"}, rw_both, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 8; i++) stat_tab[i] = 0;

    // reset state
    repeat (3) @(posedge mgmt_clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_write", av_wr, 0);
    chk("rst_read", av_rd, 0);
    chk("rst_addr", av_addr, 0);
    rst_n = 1;

    // T1: online at cycle 10, done|pass on the 3rd read, start while busy ignored
    stat_tab[0] = $urandom & ~32'h2;
    stat_tab[1] = $urandom & ~32'h2;
    stat_tab[2] = $urandom | 32'h3;
    clear_stats();
    new_cfg();
    do_start();
    chk("t1_busy_after_start", busy, 1);
    repeat (3) @(posedge mgmt_clk);
    #1 dx = ~dx; dy = ~dy; dz = ~dz; pcnt = ~pcnt; start = 1;
    @(posedge mgmt_clk); #1 start = 0;
    repeat (5) @(posedge mgmt_clk);
    #1 tx_on = 1; rx_on = 1;
    wait_done(2000, n);
    check_writes("t1");
    check_result("t1");

    // T2: waitrequest held 5 cycles on the delay-Y write
    stall_addr = A_DY; stall_cfg = 5;
    stat_tab[0] = ($urandom & ~32'h3) | 32'h3;
    clear_stats();
    new_cfg();
    do_start();
    wait_done(2000, n);
    check_writes("t2");
    check_result("t2");
    chk("t2_stable", stable_ok, 1);
    chk("t2_dy_write_cycles", wr_high_max, 6);
    stall_addr = '1; stall_cfg = 0;

    // T3: link never online
    tx_on = 0; rx_on = 0;
    clear_stats();
    new_cfg();
    do_start();
    wait_done(1000, n);
    chk("t3_cycles", n, ONLINE_TMO);
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 0);
    chk("t3_err", err, 1);
    chk("t3_nwr", wr_q.size(), 0);
    chk("t3_nreads", n_reads, 0);
    tx_on = 1; rx_on = 1;

    // T4: checker reports done without pass, then a clean rerun
    stat_tab[0] = ($urandom & ~32'h3) | 32'h2;
    clear_stats();
    new_cfg();
    do_start();
    wait_done(2000, n);
    check_writes("t4a");
    check_result("t4a");
    stat_tab[0] = 32'h3;
    clear_stats();
    new_cfg();
    do_start();
    chk("t4_restart_done_clr", done, 0);
    chk("t4_restart_err_clr", err, 0);
    chk("t4_restart_busy", busy, 1);
    wait_done(2000, n);
    check_writes("t4b");
    check_result("t4b");

    // T5a: waitrequest stuck high on the first write
    stuck = 1;
    clear_stats();
    new_cfg();
    do_start();
    wait_done(2000, n);
    chk("t5a_done", done, 1);
    chk("t5a_err", err, 2);
    chk("t5a_pass", pass, 0);
    chk("t5a_nwr", wr_q.size(), 0);
    chk("t5a_write_cycles", wr_high_max, AVMM_TMO);
    chk("t5a_write_dropped", av_wr, 0);
    stuck = 0;
    repeat (2) @(posedge mgmt_clk);

    // T5b: status never reports done
    for (int i = 0; i < 8; i++) stat_tab[i] = $urandom & ~32'h2;
    clear_stats();
    new_cfg();
    do_start();
    wait_done(4000, n);
    check_writes("t5b");
    check_result("t5b");

    // T6: asynchronous reset in the middle of a status read
    stall_addr = A_STAT; stall_cfg = 20;
    stat_tab[0] = 32'h3;
    clear_stats();
    new_cfg();
    do_start();
    n = 0;
    while (av_rd !== 1'b1 && n < 500) begin
      @(posedge mgmt_clk); #1 n++;
    end
    chk("t6_read_seen", av_rd, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_read_dropped", av_rd, 0);
    chk("t6_write_low", av_wr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_addr", av_addr, 0);
    @(posedge mgmt_clk); #1 rst_n = 1;
    stall_addr = '1; stall_cfg = 0;

    // recovery after reset
    stat_tab[0] = 32'h3;
    clear_stats();
    new_cfg();
    do_start();
    wait_done(2000, n);
    check_writes("t6r");
    check_result("t6r");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
